// File: rtl/udp_buf_pkg.sv
// Shared types and constants for the UDP frame buffer.
package udp_buf_pkg;

    // Width of stored frame lengths and of the byte counters.
    localparam int unsigned LEN_W = 16;

    // Read-side FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StSend,
        StRelease
    } rd_state_e;

    // Address width needed to cover every byte of every slot.
    function automatic int unsigned addr_width(input int unsigned num_slots,
                                               input int unsigned frame_bytes);
        return $clog2(num_slots * frame_bytes);
    endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram_1clk #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; read data holds when re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/udp_frame_buffer.sv
// Multi-slot frame buffer between the AD byte source and the UDP TX engine.
// Bytes are packed into fixed-size slots; a slot is committed when full or
// after an idle timeout, and committed slots are handed out in order.
module udp_frame_buffer
    import udp_buf_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 1024,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   wr_data,
    input  logic                         wr_en,
    output logic                         frame_tx_start,
    input  logic                         frame_tx_done,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic [15:0]                  rd_byte_num,
    output logic [$clog2(NUM_SLOTS):0]   frames_pending,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt
);

    localparam int unsigned SW      = $clog2(NUM_SLOTS);
    localparam int unsigned PW      = SW + 1;
    localparam int unsigned DEPTH   = NUM_SLOTS * FRAME_BYTES;
    localparam int unsigned AW      = addr_width(NUM_SLOTS, FRAME_BYTES);
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYC - 1 : 0;
    localparam int unsigned IW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Write side
    logic [SW-1:0]    wslot_q;
    logic [LEN_W-1:0] wcnt_q;
    logic [IW-1:0]    idle_q;
    logic [PW-1:0]    pending_q;
    logic             full;
    logic             accept;
    logic             last_byte;
    logic             timeout_hit;
    logic             commit;
    logic [LEN_W-1:0] commit_len;
    logic [AW-1:0]    waddr;

    // Length FIFO, one entry per slot, indexed by the slot pointers
    logic [LEN_W-1:0] len_mem [NUM_SLOTS];

    // Overflow accounting
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    // Read side
    rd_state_e        state_q;
    logic [SW-1:0]    rslot_q;
    logic [SW-1:0]    rslot_next;
    logic [LEN_W-1:0] rcnt_q;
    logic [LEN_W-1:0] rd_byte_num_q;
    logic             tx_start_q;
    logic             rd_hit;
    logic             rd_zero_q;
    logic             release_go;
    logic [AW-1:0]    raddr;
    logic [7:0]       ram_rdata;

    // A full buffer means there is no write slot; freed space shows up one cycle late.
    assign full        = (pending_q == PW'(NUM_SLOTS));
    assign accept      = wr_en && !full;
    assign last_byte   = accept && (wcnt_q == LEN_W'(FRAME_BYTES - 1));
    assign timeout_hit = TO_EN && !wr_en && (wcnt_q != '0) && (idle_q == IW'(TO_LAST));
    assign commit      = last_byte || timeout_hit;
    assign commit_len  = last_byte ? LEN_W'(FRAME_BYTES) : wcnt_q;
    assign waddr       = AW'(32'(wslot_q) * FRAME_BYTES + 32'(wcnt_q));

    assign release_go  = (state_q == StRelease);
    assign rslot_next  = rslot_q + 1'b1;
    assign rd_hit      = rd_en && (state_q == StSend) && (rcnt_q != rd_byte_num_q);
    assign raddr       = AW'(32'(rslot_q) * FRAME_BYTES + 32'(rcnt_q));

    // Write pointer, fill count and idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wslot_q <= '0;
            wcnt_q  <= '0;
            idle_q  <= '0;
        end else begin
            if (commit) begin
                wslot_q <= wslot_q + 1'b1;
                wcnt_q  <= '0;
            end else if (accept) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            if (wr_en || commit || (wcnt_q == '0)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

    // Record the committed length for the slot being closed.
    always_ff @(posedge clk) begin
        if (commit) begin
            len_mem[wslot_q] <= commit_len;
        end
    end

    // Committed-frame count; a commit and a release together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else if (commit && !release_go) begin
            pending_q <= pending_q + 1'b1;
        end else if (!commit && release_go) begin
            pending_q <= pending_q - 1'b1;
        end
    end

    // Dropped-byte pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= wr_en && full;
            if (wr_en && full && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    // Read FSM: hand out committed frames in order with a start/done handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rslot_q       <= '0;
            rcnt_q        <= '0;
            rd_byte_num_q <= '0;
            tx_start_q    <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pending_q != '0) begin
                        rd_byte_num_q <= len_mem[rslot_q];
                        rcnt_q        <= '0;
                        tx_start_q    <= 1'b1;
                        state_q       <= StStart;
                    end
                end
                StStart: begin
                    state_q <= StSend;
                end
                StSend: begin
                    if (rd_hit) begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                    if (frame_tx_done) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    rslot_q <= rslot_next;
                    // Another frame already waiting: skip the IDLE cycle so the
                    // next START lands two cycles after frame_tx_done.
                    if (pending_q > PW'(1)) begin
                        rd_byte_num_q <= len_mem[rslot_next];
                        rcnt_q        <= '0;
                        tx_start_q    <= 1'b1;
                        state_q       <= StStart;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Select between RAM data and the 0x00 returned for out-of-frame requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_zero_q <= 1'b1;
        end else if (rd_en) begin
            rd_zero_q <= !rd_hit;
        end
    end

    sdp_ram_1clk #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr),
        .wdata (wr_data),
        .re    (rd_hit),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign frame_tx_start = tx_start_q;
    assign rd_data        = rd_zero_q ? 8'h00 : ram_rdata;
    assign rd_byte_num    = rd_byte_num_q;
    assign frames_pending = pending_q;
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_udp_frame_buffer.sv
// Scoreboard bench for udp_frame_buffer: frames are modelled as byte queues.
module tb_udp_frame_buffer;

    localparam int unsigned FB = 1024;
    localparam int unsigned NS = 4;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_en = 1'b0;
    logic        frame_tx_start;
    logic        frame_tx_done = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic [15:0] rd_byte_num;
    logic [2:0]  frames_pending;
    logic        overflow;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    udp_frame_buffer #(
        .FRAME_BYTES (FB),
        .NUM_SLOTS   (NS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .frame_tx_start (frame_tx_start),
        .frame_tx_done  (frame_tx_done),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_byte_num    (rd_byte_num),
        .frames_pending (frames_pending),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] partial[$];
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    logic [7:0] cur_frame[$];
    logic [7:0] exp_rd[$];
    int         model_pending = 0;
    int         exp_drops = 0;
    int         ovf_seen = 0;
    logic       rd_en_cap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_model();
        exp_len.push_back(partial.size());
        foreach (partial[i]) exp_bytes.push_back(partial[i]);
        partial.delete();
        model_pending++;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (model_pending == NS) begin
            exp_drops++;
        end else begin
            partial.push_back(b);
            if (partial.size() == FB) commit_model();
        end
        tick();
    endtask

    task automatic write_stream(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            write_byte(ramp ? 8'(i) : 8'($urandom));
        end
        wr_en = 1'b0;
    endtask

    // Short frame committed by the idle timeout; returns once it is visible.
    task automatic write_timeout_frame(input int n);
        write_stream(n, 1'b0);
        commit_model();
        repeat (TO) tick();
    endtask

    task automatic wait_start();
        int k = 0;
        while (!frame_tx_start && k < 64) begin
            tick();
            k++;
        end
        check("start_seen", 32'(frame_tx_start), 32'd1);
    endtask

    task automatic read_bytes(input int extra);
        int n;
        logic [7:0] e;
        logic [7:0] last;
        last = 8'h00;
        tick();
        n = cur_frame.size();
        for (int i = 0; i < n + extra; i++) begin
            if ($urandom_range(3) == 0) begin
                rd_en = 1'b0;
                tick();
            end
            rd_en = 1'b1;
            e = (i < n) ? cur_frame[i] : 8'h00;
            exp_rd.push_back(e);
            last = e;
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        check("rd_hold", 32'(rd_data), 32'(last));
        check("rd_drained", 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic release_frame();
        frame_tx_done = 1'b1;
        model_pending--;
        tick();
        frame_tx_done = 1'b0;
        tick();
        check("pending_after_release", 32'(frames_pending), 32'(model_pending));
    endtask

    always @(posedge clk) rd_en_cap <= rd_en;

    // Monitor: consumes expectations whenever the DUT presents data or a start.
    always @(negedge clk) begin
        int n;
        if (!rst) begin
            if (rd_en_cap) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got 0x%0h with no expected byte", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
                end
            end
            if (overflow) ovf_seen++;
            if (frame_tx_start) begin
                if (exp_len.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected: got start with no committed frame");
                end else begin
                    n = exp_len.pop_front();
                    check("rd_byte_num", 32'(rd_byte_num), 32'(n));
                    cur_frame.delete();
                    repeat (n) cur_frame.push_back(exp_bytes.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // Reset values
        tick();
        tick();
        check("rst_start", 32'(frame_tx_start), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_byte_num", 32'(rd_byte_num), 32'd0);
        check("rst_pending", 32'(frames_pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Full frame of a repeating ramp; start exactly two cycles after the last byte
        write_stream(FB, 1'b1);
        check("full_pending", 32'(frames_pending), 32'd1);
        check("full_start_early", 32'(frame_tx_start), 32'd0);
        tick();
        check("full_start", 32'(frame_tx_start), 32'd1);
        read_bytes(0);
        release_frame();

        // Partial frame committed by timeout at last+TO
        write_stream(100, 1'b0);
        repeat (TO - 1) tick();
        check("to_not_yet", 32'(frames_pending), 32'd0);
        commit_model();
        tick();
        check("to_commit", 32'(frames_pending), 32'd1);
        tick();
        check("to_start", 32'(frame_tx_start), 32'd1);
        read_bytes(0);
        release_frame();

        // Overflow: five frames into four slots with no reads
        write_stream(5 * FB, 1'b0);
        tick();
        tick();
        check("ovf_pending", 32'(frames_pending), 32'(NS));
        check("ovf_pulses", 32'(ovf_seen), 32'(exp_drops));
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1024);
        for (int f = 0; f < 4; f++) begin
            if (f > 0) wait_start();
            read_bytes(0);
            release_frame();
        end

        // Last byte of one frame coincides with frame_tx_done of another
        write_stream(FB, 1'b0);
        wait_start();
        read_bytes(0);
        write_stream(FB - 1, 1'b0);
        check("coin_pre_pending", 32'(frames_pending), 32'd1);
        frame_tx_done = 1'b1;
        model_pending--;
        write_byte(8'($urandom));
        wr_en = 1'b0;
        frame_tx_done = 1'b0;
        tick();
        check("coin_pending", 32'(frames_pending), 32'(model_pending));
        check("coin_start", 32'(frame_tx_start), 32'd1);
        read_bytes(0);
        release_frame();

        // Extra rd_en past the frame end, then done while idle
        write_timeout_frame(10);
        wait_start();
        read_bytes(3);
        release_frame();
        frame_tx_done = 1'b1;
        tick();
        frame_tx_done = 1'b0;
        seen = 0;
        repeat (8) begin
            if (frame_tx_start) seen++;
            tick();
        end
        check("idle_done_start", 32'(seen), 32'd0);
        check("idle_done_pending", 32'(frames_pending), 32'd0);
        write_timeout_frame(50);
        wait_start();
        read_bytes(0);
        release_frame();

        // Reset in the middle of SEND with three frames pending
        write_timeout_frame(20);
        write_timeout_frame(20);
        write_timeout_frame(20);
        check("mid_pending", 32'(frames_pending), 32'd3);
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            exp_rd.push_back(cur_frame[i]);
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_start", 32'(frame_tx_start), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check("mid_rst_byte_num", 32'(rd_byte_num), 32'd0);
        check("mid_rst_pending", 32'(frames_pending), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        partial.delete();
        exp_bytes.delete();
        exp_len.delete();
        cur_frame.delete();
        exp_rd.delete();
        model_pending = 0;
        exp_drops = 0;
        ovf_seen = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        write_timeout_frame(30);
        wait_start();
        read_bytes(0);
        release_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
